sub_seq_chunked: RTL and testbench

//   Parametrised multi-cycle unsigned subtractor, successor to the 4-bit combinational sub.

---
 rtl/sub_seq_chunked.sv | 201 ++++++++++++++++++++
 tb/tb_sub_seq_chunked.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub_seq_chunked.sv
// -----------------------------------------------------------------------------
// sub_seq_chunked
//   Multi-cycle unsigned subtractor. Computes diff = a - b over WIDTH bits,
//   CHUNK bits per clock, least-significant chunk first, with the borrow
//   carried between cycles. Only a CHUNK-bit subtractor is built.
//
//   Optional feature macro: SUB_SAT_EN
//     defined   : a final borrow clamps diff to 0 and raises sat
//     undefined : diff is the wrapped result and sat is tied to 0
//
// Parameters
//   WIDTH  operand/result width (multiple of CHUNK)
//   CHUNK  bits subtracted per cycle (1 <= CHUNK <= WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, accepted only on an edge where ready=1
//   a, b       minuend / subtrahend, sampled at the accepting edge
//   ready      1 in IDLE and DONE, 0 in BUSY
//   done       one-cycle pulse, result valid
//   diff       (a - b) mod 2^WIDTH (clamped form under SUB_SAT_EN)
//   borrow     1 iff a < b
//   zero       1 iff reported diff == 0
//   sat        1 iff the clamp was applied
//   dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: a request is taken on any rising edge where start=1 and
// ready=1; done is high for exactly the one cycle after the last chunk
// edge, and diff/borrow/zero/sat only change on that edge (or on reset).
// -----------------------------------------------------------------------------
module sub_seq_chunked #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             sat,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bin_q, bin_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;

  // One chunk of the subtraction; bit CHUNK is the borrow out.
  logic [CHUNK:0]   step;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] final_diff;
  logic             final_sat;

  assign step = {1'b0, a_sh_q[CHUNK-1:0]}
              - {1'b0, b_sh_q[CHUNK-1:0]}
              - {{CHUNK{1'b0}}, bin_q};

  // New chunk enters from the MSB side so the LSB chunk ends up lowest.
  generate
    if (CHUNK == WIDTH) begin : g_single
      assign res_shift = step[CHUNK-1:0];
    end else begin : g_multi
      assign res_shift = {step[CHUNK-1:0], res_q[WIDTH-1:CHUNK]};
    end
  endgenerate

`ifdef SUB_SAT_EN
  logic sat_q, sat_d;
  assign final_diff = step[CHUNK] ? '0 : res_shift;
  assign final_sat  = step[CHUNK];
  assign sat        = sat_q;
`else
  assign final_diff = res_shift;
  assign final_sat  = 1'b0;
  assign sat        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    bin_d    = bin_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
`ifdef SUB_SAT_EN
    sat_d    = sat_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_BUSY;
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUSY: begin
        a_sh_d = a_sh_q >> CHUNK;
        b_sh_d = b_sh_q >> CHUNK;
        res_d  = res_shift;
        bin_d  = step[CHUNK];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // Last chunk: publish the result on this same edge.
          state_d  = ST_DONE;
          diff_d   = final_diff;
          borrow_d = step[CHUNK];
          zero_d   = (final_diff == '0);
`ifdef SUB_SAT_EN
          sat_d    = final_sat;
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      bin_q    <= bin_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

`ifdef SUB_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end
`else
  // final_sat only matters when the clamp is built.
  logic unused_sat;
  assign unused_sat = final_sat;
`endif

  assign ready     = (state_q != ST_BUSY);
  assign done      = (state_q == ST_DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sub_seq_chunked.sv
// -----------------------------------------------------------------------------
// tb_sub_seq_chunked
//   Six instances: WIDTH=4/CHUNK=2, WIDTH=8 with CHUNK 1,2,4,8, and
//   WIDTH=16/CHUNK=4. Each has its own driver, expected queue and monitor.
//   The reference is plain a-b arithmetic on the full operands.
// -----------------------------------------------------------------------------
module tb_sub_seq_chunked;

  localparam int NCFG = 6;

  logic clk = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   fin_cnt = 0;

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar g;
  for (g = 0; g < NCFG; g++) begin : cfg
    localparam int W  = (g == 0) ? 4 : (g == 5) ? 16 : 8;
    localparam int CH = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 2 :
                        (g == 3) ? 4 : (g == 4) ? 8 : 4;
    localparam int NC = W / CH;
    localparam logic [W+2:0] RST_VEC = {{W{1'b0}}, 1'b0, 1'b1, 1'b0};

    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready, done, borrow, zero, sat;
    logic [W-1:0] diff;
    logic [1:0]   dbg_state;

    sub_seq_chunked #(.WIDTH(W), .CHUNK(CH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .ready    (ready),
      .done     (done),
      .diff     (diff),
      .borrow   (borrow),
      .zero     (zero),
      .sat      (sat),
      .dbg_state(dbg_state)
    );

    // scoreboard: expected {diff,borrow,zero,sat} and expected done cycle
    logic [W+2:0] exp_q[$];
    int           cyc_q[$];
    logic [W+2:0] last = RST_VEC;
    logic [W+2:0] e;
    int           ec;

    logic [15:0] da [7] = '{16'h0006, 16'h0002, 16'h1000, 16'h1234,
                            16'h0000, 16'hFFFF, 16'h0005};
    logic [15:0] db [7] = '{16'h0003, 16'h0007, 16'h0001, 16'h1234,
                            16'h0001, 16'hFFFF, 16'h0008};

    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] d;
      logic         br;
      d  = x - y;
      br = (x < y);
`ifdef SUB_SAT_EN
      if (br) return {{W{1'b0}}, 1'b1, 1'b1, 1'b1};
      return {d, 1'b0, (d == '0), 1'b0};
`else
      return {d, br, (d == '0), 1'b0};
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cfg%0d %s: got %0h want %0h", g, nm, got, want);
      end
    endtask

    // driver: wait (with noise) until ready, then present one request
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input int idle);
      int n;
      n = 0;
      @(posedge clk); #1;
      repeat (idle) begin
        start = 1'b0;
        @(posedge clk); #1;
      end
      while (!ready && n < 200) begin
        start = 1'($urandom_range(0, 1));
        a     = W'($urandom);
        b     = W'($urandom);
        @(posedge clk); #1;
        n++;
      end
      if (!ready) begin
        checks++;
        errors++;
        $display("FAIL cfg%0d ready_timeout: got ready=0 want ready=1", g);
        start = 1'b0;
      end else begin
        start = 1'b1;
        a     = x;
        b     = y;
        exp_q.push_back(model(x, y));
        cyc_q.push_back(cyc + 1 + NC);
      end
    endtask

    task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"},  32'(ready),  32'd1);
      chk({tag, "_done"},   32'(done),   32'd0);
      chk({tag, "_diff"},   32'(diff),   32'd0);
      chk({tag, "_borrow"}, 32'(borrow), 32'd0);
      chk({tag, "_zero"},   32'(zero),   32'd1);
      chk({tag, "_sat"},    32'(sat),    32'd0);
    endtask

    // monitor
    always @(negedge clk) begin
      if (!rst_n) begin
        exp_q.delete();
        cyc_q.delete();
        last = RST_VEC;
      end else if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cfg%0d unexpected_done: got done=1 want done=0 at cycle %0d", g, cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = cyc_q.pop_front();
          chk("result", 32'({diff, borrow, zero, sat}), 32'(e));
          chk("done_cycle", 32'(cyc), 32'(ec));
          last = e;
        end
      end else begin
        chk("hold", 32'({diff, borrow, zero, sat}), 32'(last));
      end
    end

    initial begin
      logic [W-1:0] x, y;
      int n;

      // reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      // directed vectors, issued back-to-back
      for (int i = 0; i < 7; i++) begin
        x = da[i][W-1:0];
        y = db[i][W-1:0];
        issue(x, y, 0);
      end

      // reset in the middle of an operation
      issue(W'(5), W'(3), 1);
      repeat ((NC >= 2) ? 2 : 1) begin
        @(posedge clk); #1;
      end
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midop_reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      issue(W'(5), W'(3), 0);

      // random operations
      for (int i = 0; i < 500; i++) begin
        x = W'($urandom);
        y = ($urandom_range(0, 7) == 0) ? x : W'($urandom);
        issue(x, y, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
      @(posedge clk); #1;
      start = 1'b0;

      // drain
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL cfg%0d drain: got %0d pending want 0", g, exp_q.size());
      end
      fin_cnt++;
    end
  end

  // final report
  initial begin
    fork
      begin
        wait (fin_cnt == NCFG);
      end
      begin
        repeat (60000) @(posedge clk);
        checks++;
        errors++;
        $display("FAIL global_timeout: got %0d finished want %0d", fin_cnt, NCFG);
      end
    join_any
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
